// File: rtl/countdown_timer_4bit.sv
// Loadable 4-bit down-counter / timer.
// Load a value and start it. It then counts down one step on each enabled
// cycle and gives a one-cycle done pulse when it reaches zero. With
// auto_reload set, it reloads and keeps running, so it acts as a periodic
// tick generator.
// The structure matches the up-counter: next-count logic feeds per-bit 2:1
// muxes in front of the count flip-flops.

module countdown_timer_4bit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_data,
    input  logic       start,
    input  logic       en,
    input  logic       auto_reload,
    output logic [3:0] count,
    output logic       busy,
    output logic       done,
    output logic       zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] reload_reg;
    logic [3:0] count_cand;
    logic       count_sel;
    logic [3:0] count_d;

    // Decrement that floors at zero; zero is terminal and never wraps to F.
    function automatic logic [3:0] dec_floor(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    // Next-count candidate plus a select saying whether count changes this cycle.
    always_comb begin
        count_cand = count;
        count_sel  = 1'b0;
        if (load) begin
            count_cand = load_data;
            count_sel  = 1'b1;
        end else if (state == RUN && en) begin
            count_sel = 1'b1;
            if (count != 4'd0)
                count_cand = dec_floor(count);
            else if (auto_reload && reload_reg != 4'd0)
                count_cand = reload_reg;
            else
                count_cand = 4'd0;
        end
    end

    // Per-bit 2:1 mux: hold the current bit or take the candidate bit.
    for (genvar i = 0; i < 4; i++) begin : g_bit_mux
        assign count_d[i] = count_sel ? count_cand[i] : count[i];
    end

    // Control FSM and all registered state; reset beats load, load beats the FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count      <= 4'd0;
            reload_reg <= 4'd0;
            state      <= IDLE;
            done       <= 1'b0;
        end else begin
            done  <= 1'b0;
            count <= count_d;
            if (load) begin
                reload_reg <= load_data;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && count != 4'd0)
                            state <= RUN;
                    end
                    RUN: begin
                        if (en) begin
                            if (count == 4'd1)
                                done <= 1'b1;
                            else if (count == 4'd0 && !(auto_reload && reload_reg != 4'd0))
                                state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RUN);
    assign zero = (count == 4'd0);

endmodule

// File: tb/tb_countdown_timer_4bit.sv
// Directed testbench for countdown_timer_4bit.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the rising edge. Each vector holds the inputs for one edge and the
// outputs expected just after that edge.

module tb_countdown_timer_4bit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic [3:0] load_data;
    logic       start;
    logic       en;
    logic       auto_reload;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_timer_4bit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_data  (load_data),
        .start      (start),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .zero       (zero)
    );

    typedef struct {
        logic       rn;
        logic       ld;
        logic [3:0] d;
        logic       st;
        logic       en;
        logic       ar;
        logic [3:0] e_cnt;
        logic       e_busy;
        logic       e_done;
        logic       e_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rn, input logic ld, input logic [3:0] d,
                                input logic st, input logic e, input logic ar,
                                input logic [3:0] c, input logic b, input logic dn,
                                input logic z);
        vec_t v;
        v.rn = rn; v.ld = ld; v.d = d; v.st = st; v.en = e; v.ar = ar;
        v.e_cnt = c; v.e_busy = b; v.e_done = dn; v.e_zero = z;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic ld, input logic [3:0] d,
                        input logic st, input logic e, input logic ar);
        @(negedge clk);
        reset_n = rn; load = ld; load_data = d; start = st; en = e; auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int idx, input logic [3:0] c, input logic b,
                              input logic dn, input logic z);
        chk("count", idx, count, c);
        chk("busy",  idx, {3'b0, busy}, {3'b0, b});
        chk("done",  idx, {3'b0, done}, {3'b0, dn});
        chk("zero",  idx, {3'b0, zero}, {3'b0, z});
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; load_data = 4'h0;
        start = 1'b0; en = 1'b0; auto_reload = 1'b0;

        //                rn ld d     st en ar   cnt   busy done zero
        // Reset, including reset held while load/start are asserted
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0,  4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 4'h7, 1, 1, 0,  4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 4'hF, 0, 1, 1,  4'h0, 0, 0, 1));
        // Load 3, start, run to zero, then drop to idle
        vecs.push_back(mk(1, 1, 4'h3, 0, 0, 0,  4'h3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 1, 0,  4'h3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h0, 0, 0, 1));
        // Start with count already zero is ignored
        vecs.push_back(mk(1, 0, 4'h0, 1, 1, 0,  4'h0, 0, 0, 1));
        // Load 0 then start: stays idle, no done
        vecs.push_back(mk(1, 1, 4'h0, 0, 1, 0,  4'h0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'h0, 1, 1, 0,  4'h0, 0, 0, 1));
        // Auto-reload with 2: period of 3, busy stays high; start in RUN ignored
        vecs.push_back(mk(1, 1, 4'h2, 0, 0, 1,  4'h2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 1, 1,  4'h2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1,  4'h1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1,  4'h0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1,  4'h2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 1, 1,  4'h1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1,  4'h0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 1,  4'h0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1,  4'h2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1,  4'h1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 1,  4'h0, 1, 1, 1));
        // auto_reload cleared mid-run: stop at zero
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h0, 0, 0, 1));
        // Load 5, start, enable pattern 1,0,0,1,1
        vecs.push_back(mk(1, 1, 4'h5, 0, 0, 0,  4'h5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 1, 0,  4'h5, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0,  4'h4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0,  4'h4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h2, 1, 0, 0));
        // Load 1, start, reset at count==1: no done
        vecs.push_back(mk(1, 1, 4'h1, 0, 0, 0,  4'h1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 0, 0,  4'h1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 4'h0, 0, 1, 0,  4'h0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h0, 0, 0, 1));
        // Load 4, start, run to 2, then reload 9 (start in same cycle ignored)
        vecs.push_back(mk(1, 1, 4'h4, 0, 0, 0,  4'h4, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 1, 1, 0,  4'h4, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4'h9, 1, 1, 0,  4'h9, 0, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 1, 0,  4'h9, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rn, vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].en, vecs[i].ar);
            check_outs(i, vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_zero);
        end

        // Later start runs the loaded 9 all the way down to zero
        step(1, 0, 4'h0, 1, 1, 0);
        check_outs(100, 4'h9, 1, 0, 0);
        for (int k = 8; k >= 1; k--) begin
            step(1, 0, 4'h0, 0, 1, 0);
            check_outs(100 + (9 - k), 4'(k), 1, 0, 0);
        end
        step(1, 0, 4'h0, 0, 1, 0);
        check_outs(109, 4'h0, 1, 1, 1);
        step(1, 0, 4'h0, 0, 1, 0);
        check_outs(110, 4'h0, 0, 0, 1);
        step(1, 0, 4'h0, 0, 1, 0);
        check_outs(111, 4'h0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
